// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    // True when addr is word aligned and maps to a word inside [base, base + 4*depth).
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned depth);
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && ((off >> 2) < depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Program store: asynchronous read port, synchronous write port, no reset.
module imem_array #(
    parameter int unsigned DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory slave: accepts fetch requests, waits WAIT_CYCLES, returns one word per request.
//   state | meaning
//   IDLE  | no request pending; accept instr_req
//   WAIT  | request latched, counting down wait states
//   RESP  | store read for req_addr; outputs capture at the closing edge, ack follows
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_ack,
    output logic [31:0] instr_mem,
    output logic        instr_err,
    output logic        busy,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic        accept;
    logic        rd_ok;
    logic        wr_ok;
    logic [31:0] rd_data;

    assign rd_ok = addr_ok(req_addr, BASE_ADDR, DEPTH);
    assign wr_ok = addr_ok(load_addr, BASE_ADDR, DEPTH);

    imem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .rd_idx  (IDX_W'((req_addr - BASE_ADDR) >> 2)),
        .rd_data (rd_data),
        .wr_en   (load_en && wr_ok),
        .wr_idx  (IDX_W'((load_addr - BASE_ADDR) >> 2)),
        .wr_data (load_data)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        req_addr_nxt = req_addr;
        accept       = 1'b0;
        case (state)
            IDLE: accept = instr_req;
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                accept    = instr_req;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            req_addr_nxt = instr_addr;
            if (WAIT_CYCLES == 0) begin
                state_nxt = RESP;
            end else begin
                state_nxt = WAIT;
                cnt_nxt   = CNT_LOAD;
            end
        end
    end

    // Read happens during RESP, before any same-edge load write lands in the store.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_addr  <= 32'd0;
            instr_ack <= 1'b0;
            instr_err <= 1'b0;
            instr_mem <= 32'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_addr  <= req_addr_nxt;
            instr_ack <= (state == RESP);
            busy      <= (state_nxt != IDLE) || (state == RESP);
            if (state == RESP) begin
                instr_mem <= rd_ok ? rd_data : NOP_INSTR;
                instr_err <= !rd_ok;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder at WAIT_CYCLES = 0, 2 and 3 sharing one stimulus bus.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rstn0, rstn2, rstn3;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic        load_en;
    logic [31:0] load_addr, load_data;
    logic        ack0, err0, busy0;
    logic        ack2, err2, busy2;
    logic        ack3, err3, busy3;
    logic [31:0] mem0, mem2, mem3;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic [31:0] model [1024];
    resp_t       sb [$];

    always #5 clk = ~clk;

    imem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn0), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(ack0), .instr_mem(mem0), .instr_err(err0), .busy(busy0),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    imem_responder #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rstn(rstn2), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(ack2), .instr_mem(mem2), .instr_err(err2), .busy(busy2),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    imem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn3), .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_ack(ack3), .instr_mem(mem3), .instr_err(err3), .busy(busy3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    function automatic resp_t expect_for(input logic [31:0] a);
        resp_t r;
        if (a[1:0] != 2'b00 || a >= 32'h0000_1000) begin
            r.data = 32'h0000_0013;
            r.err  = 1'b1;
        end else begin
            r.data = model[a[11:2]];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic sel_ack(input int which);
        return (which == 0) ? ack0 : (which == 2) ? ack2 : ack3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        instr_req = 1'b0;
        repeat (8) step();
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
        model[a[11:2]] = d;
    endtask

    task automatic wait_ack(input int which, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sel_ack(which) && n < limit);
    endtask

    task automatic test_reset();
        rstn0 = 1'b1; rstn2 = 1'b1; rstn3 = 1'b1;
        instr_req = 1'b0; instr_addr = 32'd0;
        load_en = 1'b0; load_addr = 32'd0; load_data = 32'd0;
        #2;
        rstn0 = 1'b0; rstn2 = 1'b0; rstn3 = 1'b0;
        #1;
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err0); end
        total++; if (mem0 !== 32'd0) begin bad++; $display("FAIL reset_mem: got %h want 0", mem0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
        step();
        step();
        rstn0 = 1'b1; rstn2 = 1'b1; rstn3 = 1'b1;
        step();
    endtask

    task automatic test_basic();
        resp_t e;
        int    n;
        load_word(32'h000, 32'h0050_0093);
        load_word(32'h004, 32'h00A0_0113);
        load_word(32'h008, 32'h0020_81B3);
        load_word(32'h00C, 32'h0000_0263);
        load_word(32'h010, 32'h4000_0237);
        load_word(32'h020, 32'hFEDC_BA98);
        load_word(32'hFFC, 32'h1234_5678);
        settle();
        instr_req = 1'b1; instr_addr = 32'h0;
        sb.push_back(expect_for(32'h0));
        step();
        instr_req = 1'b0;
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy0); end
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL basic_early_ack: got %b want 0", ack0); end
        wait_ack(0, 20, n);
        total++; if (n != 1) begin bad++; $display("FAIL basic_latency: got %0d want 1", n); end
        e = sb.pop_front();
        total++; if (mem0 !== e.data) begin bad++; $display("FAIL basic_data: got %h want %h", mem0, e.data); end
        total++; if (err0 !== e.err) begin bad++; $display("FAIL basic_err: got %b want %b", err0, e.err); end
        step();
        total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", ack0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy0); end
        total++; if (mem0 !== e.data) begin bad++; $display("FAIL basic_hold: got %h want %h", mem0, e.data); end
    endtask

    task automatic test_stream();
        resp_t e;
        int acks, first, last;
        settle();
        sb.delete();
        acks = 0; first = -1; last = -1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                instr_req  = 1'b1;
                instr_addr = 32'(4 * i);
                sb.push_back(expect_for(32'(4 * i)));
            end else begin
                instr_req = 1'b0;
            end
            step();
            if (ack0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL stream_extra_ack: got ack at step %0d want none", i);
                end else begin
                    e = sb.pop_front();
                    if (mem0 !== e.data || err0 !== e.err) begin
                        bad++; $display("FAIL stream_data: got %h/%b want %h/%b", mem0, err0, e.data, e.err);
                    end
                end
                acks++;
                if (first < 0) first = i;
                last = i;
            end
        end
        total++; if (acks != 4) begin bad++; $display("FAIL stream_count: got %0d want 4", acks); end
        total++; if (first != 1) begin bad++; $display("FAIL stream_first: got %0d want 1", first); end
        total++; if (last != 4) begin bad++; $display("FAIL stream_last: got %0d want 4", last); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_pending: got %0d want 0", sb.size()); end
    endtask

    task automatic test_wait2();
        resp_t e;
        int    n;
        settle();
        sb.delete();
        instr_req = 1'b1; instr_addr = 32'h10;
        sb.push_back(expect_for(32'h10));
        step();
        instr_req  = 1'b0;
        instr_addr = 32'h20;
        total++; if (busy2 !== 1'b1) begin bad++; $display("FAIL wait2_busy: got %b want 1", busy2); end
        wait_ack(2, 20, n);
        total++; if (n != 3) begin bad++; $display("FAIL wait2_latency: got %0d want 3", n); end
        e = sb.pop_front();
        total++; if (mem2 !== e.data) begin bad++; $display("FAIL wait2_data: got %h want %h", mem2, e.data); end
        total++; if (err2 !== 1'b0) begin bad++; $display("FAIL wait2_err: got %b want 0", err2); end
        step();
        total++; if (ack2 !== 1'b0) begin bad++; $display("FAIL wait2_pulse: got %b want 0", ack2); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        resp_t e;
        int    n;
        addrs = '{32'h0000_0002, 32'h0000_1000, 32'h0000_0FFC, 32'hFFFF_FFFC};
        settle();
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            instr_req = 1'b1; instr_addr = addrs[i];
            sb.push_back(expect_for(addrs[i]));
            step();
            instr_req = 1'b0;
            wait_ack(0, 20, n);
            total++; if (n != 1) begin bad++; $display("FAIL err_latency[%h]: got %0d want 1", addrs[i], n); end
            e = sb.pop_front();
            total++; if (mem0 !== e.data) begin bad++; $display("FAIL err_data[%h]: got %h want %h", addrs[i], mem0, e.data); end
            total++; if (err0 !== e.err) begin bad++; $display("FAIL err_flag[%h]: got %b want %b", addrs[i], err0, e.err); end
        end
    endtask

    task automatic test_collision();
        resp_t e;
        int    n;
        settle();
        sb.delete();
        instr_req = 1'b1; instr_addr = 32'h8;
        sb.push_back(expect_for(32'h8));
        step();
        instr_req = 1'b0;
        load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
        step();
        load_en = 1'b0;
        model[2] = 32'hDEAD_BEEF;
        total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL coll_ack: got %b want 1", ack0); end
        e = sb.pop_front();
        total++; if (mem0 !== e.data) begin bad++; $display("FAIL coll_old_data: got %h want %h", mem0, e.data); end
        settle();
        instr_req = 1'b1; instr_addr = 32'h8;
        sb.push_back(expect_for(32'h8));
        step();
        instr_req = 1'b0;
        wait_ack(0, 20, n);
        e = sb.pop_front();
        total++; if (mem0 !== e.data) begin bad++; $display("FAIL coll_new_data: got %h want %h", mem0, e.data); end
    endtask

    task automatic test_reset_mid();
        resp_t e;
        int    n;
        logic  seen;
        settle();
        sb.delete();
        instr_req = 1'b1; instr_addr = 32'h0;
        step();
        instr_req = 1'b0;
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL rmid_busy: got %b want 1", busy3); end
        step();
        rstn3 = 1'b0;
        #1;
        total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL rmid_busy_rst: got %b want 0", busy3); end
        step();
        step();
        rstn3 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ack3 || busy3) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_ghost_ack: got %b want 0", seen); end
        instr_req = 1'b1; instr_addr = 32'h4;
        sb.push_back(expect_for(32'h4));
        step();
        instr_req = 1'b0;
        wait_ack(3, 20, n);
        total++; if (n != 4) begin bad++; $display("FAIL rmid_latency: got %0d want 4", n); end
        e = sb.pop_front();
        total++; if (mem3 !== e.data) begin bad++; $display("FAIL rmid_data: got %h want %h", mem3, e.data); end
        total++; if (err3 !== e.err) begin bad++; $display("FAIL rmid_err: got %b want %b", err3, e.err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_wait2();
        test_errors();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory slave that serves the fetch stage's request/acknowledge interface (instr_addr, instr_req, instr_ack, instr_mem).
- Holds a word-addressed program store and returns one 32-bit instruction per accepted request, after a configurable number of wait states.
- Also provides a write-only load port, used by the testbench or boot loader to preload the program.
- Sits between the core's fetch stage and the instruction RAM/ROM.

Parameters:
- DEPTH, 1024, number of 32-bit words in the store (power of two, >=2).
- WAIT_CYCLES, 0, extra cycles between request acceptance and ack (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- NOP_INSTR, 32'h0000_0013, data returned on an error response (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- instr_addr  in  32  byte address of the requested instruction.
- instr_req  in  1  level request from fetch.
- instr_ack  out  1  one-cycle pulse: instr_mem now holds the response.
- instr_mem  out  32  instruction data; held stable until the next ack.
- instr_err  out  1  qualifies ack: address misaligned or out of range.
- busy  out  1  a request is accepted and not yet acked.
- load_en  in  1  write strobe for the load port.
- load_addr  in  32  byte address for the load write.
- load_data  in  32  word to write.

Behaviour:
Reset values
- instr_ack=0, instr_err=0, instr_mem=0, busy=0, state=IDLE, wait counter=0.
- Store contents are not reset.
- Reset asserted mid-operation discards any pending request; no ack is issued for it.

State machine: IDLE, WAIT, RESP
- IDLE: if instr_req=1 at a clock edge, latch instr_addr into req_addr.
  - WAIT_CYCLES=0: go to RESP.
  - Otherwise: load counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement counter each cycle; when the counter is 0, go to RESP. instr_req and instr_addr are ignored while in WAIT.
- RESP: instr_ack=1 for exactly this cycle.
  - If instr_req=1 at the closing edge, accept the new instr_addr exactly as IDLE does (back-to-back).
  - Otherwise go to IDLE.

Timing
- Latency: request sampled at edge N gives instr_ack high in the cycle after edge N+1+WAIT_CYCLES.
- Throughput: one instruction per (1+WAIT_CYCLES) cycles with continuous instr_req. With WAIT_CYCLES=0, ack is high on every cycle.
- busy=1 from the acceptance edge until the edge that ends the RESP cycle, unless a new request is accepted at that edge.

Outputs (all registered)
- instr_mem and instr_err update on the edge entering RESP and hold until the next RESP entry.

Response data
- word index = (req_addr-BASE_ADDR)>>2.
- instr_err=1 and instr_mem=NOP_INSTR if req_addr[1:0]!=0, or req_addr<BASE_ADDR, or index>=DEPTH.
- Otherwise instr_err=0 and instr_mem=store[index].
- Address arithmetic is 32-bit unsigned; subtraction wrap below BASE_ADDR counts as out of range.

Fetch-side behaviour
- A changed instr_addr while a request is pending does not abort it; the original address is served.
- The fetch stage discards responses it no longer needs.
- Deasserting instr_req during WAIT does not cancel the pending ack.

Load port
- Independent of the state machine.
- Writes on any edge with load_en=1 if the load address is aligned and in range; otherwise the write is silently dropped.
- Read-before-write: a write on the same edge as RESP entry to the same word is not visible in that response. It is visible to later requests.

Decomposition:
- Package imem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the NOP_INSTR default;
  - the address-check function (aligned and in range for BASE_ADDR/DEPTH).
- One sub-module, imem_array:
  - DEPTH x 32 store;
  - one combinational read port indexed by req_addr;
  - one synchronous write port.
- The FSM, counter and output registers live in imem_responder.

Test Plan:
- Reset with WAIT_CYCLES=0: outputs 0, busy 0. Preload word0=32'h00500093. Request 0x0 at edge 1 -> ack=1 in cycle 2, instr_mem=32'h00500093, err=0.
- Streaming, WAIT_CYCLES=0: requests 0x0, 0x4, 0x8, 0xC held continuously -> ack high on 4 consecutive cycles, data equals words 0..3 in order.
- WAIT_CYCLES=2: request 0x10 sampled at edge N -> ack only in the cycle after edge N+3. Changing instr_addr to 0x20 during WAIT still returns word 4.
- Errors, DEPTH=1024: request 0x2 -> ack with err=1 and data 32'h00000013. Request 0x1000 -> same. Request 0xFFC -> err=0.
- Load collision, WAIT_CYCLES=0: load_en to 0x8 with 32'hDEADBEEF on the RESP-entry edge of request 0x8 -> old data returned. Next request to 0x8 -> 32'hDEADBEEF.
- Reset mid-request, WAIT_CYCLES=3: assert rstn=0 during WAIT -> ack never rises for that request, busy=0. After release, a new request completes normally.
